// File: rtl/sparc_decode_execute_core_pkg.sv
// Shared encodings for the SPARC-subset decode/execute slice: ALU opcodes,
// instruction field values, Bicc condition codes and control-word bit positions.
package sparc_decode_execute_core_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_ADDX  = 4'h1,
      ALU_SUB   = 4'h2,
      ALU_SUBX  = 4'h3,
      ALU_AND   = 4'h4,
      ALU_OR    = 4'h5,
      ALU_XOR   = 4'h6,
      ALU_XNOR  = 4'h7,
      ALU_ANDN  = 4'h8,
      ALU_ORN   = 4'h9,
      ALU_SLL   = 4'hA,
      ALU_SRL   = 4'hB,
      ALU_SRA   = 4'hC,
      ALU_PASSA = 4'hD,
      ALU_PASSB = 4'hE,
      ALU_NOTB  = 4'hF
   } alu_op_e;

   localparam logic [1:0] OP_BR    = 2'b00;
   localparam logic [1:0] OP_CALL  = 2'b01;
   localparam logic [1:0] OP_ARITH = 2'b10;
   localparam logic [1:0] OP_MEM   = 2'b11;

   localparam logic [2:0] OP2_BICC  = 3'b010;
   localparam logic [2:0] OP2_SETHI = 3'b100;

   // op3 values of the non-cc ALU group; the cc forms differ only in op3[4]
   localparam logic [5:0] OP3_ADD     = 6'h00;
   localparam logic [5:0] OP3_AND     = 6'h01;
   localparam logic [5:0] OP3_OR      = 6'h02;
   localparam logic [5:0] OP3_XOR     = 6'h03;
   localparam logic [5:0] OP3_SUB     = 6'h04;
   localparam logic [5:0] OP3_ANDN    = 6'h05;
   localparam logic [5:0] OP3_ORN     = 6'h06;
   localparam logic [5:0] OP3_XNOR    = 6'h07;
   localparam logic [5:0] OP3_ADDX    = 6'h08;
   localparam logic [5:0] OP3_SUBX    = 6'h0C;
   localparam logic [5:0] OP3_SLL     = 6'h25;
   localparam logic [5:0] OP3_SRL     = 6'h26;
   localparam logic [5:0] OP3_SRA     = 6'h27;
   localparam logic [5:0] OP3_JMPL    = 6'h38;
   localparam logic [5:0] OP3_SAVE    = 6'h3C;
   localparam logic [5:0] OP3_RESTORE = 6'h3D;

   // Lower half of the Bicc table; cond[3] inverts these
   localparam logic [2:0] COND_N   = 3'd0;
   localparam logic [2:0] COND_E   = 3'd1;
   localparam logic [2:0] COND_LE  = 3'd2;
   localparam logic [2:0] COND_L   = 3'd3;
   localparam logic [2:0] COND_LEU = 3'd4;
   localparam logic [2:0] COND_CS  = 3'd5;
   localparam logic [2:0] COND_NEG = 3'd6;
   localparam logic [2:0] COND_VS  = 3'd7;

   localparam int unsigned ICC_N = 3;
   localparam int unsigned ICC_Z = 2;
   localparam int unsigned ICC_V = 1;
   localparam int unsigned ICC_C = 0;

   localparam int unsigned CW_JMPL      = 15;
   localparam int unsigned CW_RW        = 14;
   localparam int unsigned CW_ALU_HI    = 13;
   localparam int unsigned CW_ALU_LO    = 10;
   localparam int unsigned CW_SE_DM     = 9;
   localparam int unsigned CW_LOAD      = 8;
   localparam int unsigned CW_RF_EN     = 7;
   localparam int unsigned CW_SIZE_HI   = 6;
   localparam int unsigned CW_SIZE_LO   = 5;
   localparam int unsigned CW_MODIFY_CC = 4;
   localparam int unsigned CW_CALL      = 3;
   localparam int unsigned CW_DM_EN     = 2;
   localparam int unsigned CW_B_INSTR   = 1;
   localparam int unsigned CW_A         = 0;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   // Returns {recognised, alu_op} for an op=10 instruction
   function automatic logic [4:0] arith_decode(input logic [5:0] op3);
      logic [4:0] r;
      r = '0;
      if (!op3[5]) begin
         case ({2'b00, op3[3:0]})
            OP3_ADD:  r = {1'b1, ALU_ADD};
            OP3_ADDX: r = {1'b1, ALU_ADDX};
            OP3_SUB:  r = {1'b1, ALU_SUB};
            OP3_SUBX: r = {1'b1, ALU_SUBX};
            OP3_AND:  r = {1'b1, ALU_AND};
            OP3_OR:   r = {1'b1, ALU_OR};
            OP3_XOR:  r = {1'b1, ALU_XOR};
            OP3_XNOR: r = {1'b1, ALU_XNOR};
            OP3_ANDN: r = {1'b1, ALU_ANDN};
            OP3_ORN:  r = {1'b1, ALU_ORN};
            default:  r = '0;
         endcase
      end else begin
         case (op3)
            OP3_SLL:                        r = {1'b1, ALU_SLL};
            OP3_SRL:                        r = {1'b1, ALU_SRL};
            OP3_SRA:                        r = {1'b1, ALU_SRA};
            OP3_JMPL, OP3_SAVE, OP3_RESTORE: r = {1'b1, ALU_ADD};
            default:                        r = '0;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/sparc_alu32.sv
// 32-bit EX-stage ALU with N/Z/V/C; C and V are only meaningful for add/sub.
module sparc_alu32
   import sparc_decode_execute_core_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  alu_op,
   input  logic        cin,
   output logic [31:0] result,
   output logic [3:0]  flags
);

   logic [32:0] sum;
   logic [32:0] diff;
   logic        ci;
   logic        v;
   logic        c;
   logic [4:0]  shamt;

   always_comb begin
      // Only ADDX/SUBX (odd arithmetic opcodes) consume the stored carry
      ci     = cin & alu_op[0];
      shamt  = b[4:0];
      sum    = {1'b0, a} + {1'b0, b} + {32'd0, ci};
      diff   = {1'b0, a} - {1'b0, b} - {32'd0, ci};
      result = '0;
      v      = 1'b0;
      c      = 1'b0;
      case (alu_op)
         ALU_ADD, ALU_ADDX: begin
            result = sum[31:0];
            c      = sum[32];
            v      = (a[31] == b[31]) && (sum[31] != a[31]);
         end
         ALU_SUB, ALU_SUBX: begin
            result = diff[31:0];
            c      = diff[32];
            v      = (a[31] != b[31]) && (diff[31] != a[31]);
         end
         ALU_AND:   result = a & b;
         ALU_OR:    result = a | b;
         ALU_XOR:   result = a ^ b;
         ALU_XNOR:  result = ~(a ^ b);
         ALU_ANDN:  result = a & ~b;
         ALU_ORN:   result = a | ~b;
         ALU_SLL:   result = a << shamt;
         ALU_SRL:   result = a >> shamt;
         ALU_SRA:   result = 32'($signed(a) >>> shamt);
         ALU_PASSA: result = a;
         ALU_PASSB: result = b;
         ALU_NOTB:  result = ~b;
         default:   result = '0;
      endcase
      flags = {result[31], (result == 32'd0), v, c};
   end

endmodule

// File: rtl/sparc_decode_execute_core.sv
// Decode/execute slice: ID control decoder, EX ALU, Bicc evaluation and the
// PSR icc register that supplies carry-in and branch conditions.
module sparc_decode_execute_core
   import sparc_decode_execute_core_pkg::*;
(
   input  logic        Clk,
   input  logic        R,
   input  logic [31:0] id_instr,
   output logic [15:0] ctrl_word,
   input  logic [3:0]  ex_alu_op,
   input  logic [31:0] ex_a,
   input  logic [31:0] ex_b,
   input  logic        ex_modify_cc,
   output logic [31:0] alu_out,
   output logic [3:0]  alu_flags,
   output logic [3:0]  psr_cc,
   output logic        branch_taken
);

   logic [3:0]  psr_cc_q;
   logic [3:0]  psr_cc_d;
   logic [15:0] ctrl;
   logic [1:0]  op;
   logic [2:0]  op2;
   logic [5:0]  op3;
   logic [4:0]  arith;
   logic [3:0]  cc;
   logic        cond_base;

   sparc_alu32 u_alu (
      .a      (ex_a),
      .b      (ex_b),
      .alu_op (ex_alu_op),
      .cin    (psr_cc_q[ICC_C]),
      .result (alu_out),
      .flags  (alu_flags)
   );

   always_comb begin
      op    = id_instr[31:30];
      op2   = id_instr[24:22];
      op3   = id_instr[24:19];
      arith = arith_decode(op3);
      ctrl  = '0;
      // The all-zero word is the canonical NOP (SETHI 0,%g0) and decodes to nothing
      if (id_instr != 32'd0) begin
         case (op)
            OP_CALL: begin
               ctrl[CW_CALL]  = 1'b1;
               ctrl[CW_RF_EN] = 1'b1;
            end
            OP_BR: begin
               if (op2 == OP2_BICC) begin
                  ctrl[CW_B_INSTR] = 1'b1;
                  ctrl[CW_A]       = id_instr[29];
               end else if (op2 == OP2_SETHI) begin
                  ctrl[CW_RF_EN]              = 1'b1;
                  ctrl[CW_ALU_HI:CW_ALU_LO]   = ALU_PASSB;
               end
            end
            OP_ARITH: begin
               if (arith[4]) begin
                  ctrl[CW_RF_EN]            = 1'b1;
                  ctrl[CW_MODIFY_CC]        = op3[4];
                  ctrl[CW_ALU_HI:CW_ALU_LO] = arith[3:0];
                  ctrl[CW_JMPL]             = (op3 == OP3_JMPL);
               end
            end
            OP_MEM: begin
               if (op3[5:4] == 2'b00 && op3[1:0] != 2'b11) begin
                  ctrl[CW_DM_EN] = 1'b1;
                  ctrl[CW_RW]    = op3[2];
                  ctrl[CW_LOAD]  = ~op3[2];
                  ctrl[CW_RF_EN] = ~op3[2];
                  ctrl[CW_SE_DM] = op3[3];
                  case (op3[1:0])
                     2'b00:   ctrl[CW_SIZE_HI:CW_SIZE_LO] = SZ_WORD;
                     2'b01:   ctrl[CW_SIZE_HI:CW_SIZE_LO] = SZ_BYTE;
                     default: ctrl[CW_SIZE_HI:CW_SIZE_LO] = SZ_HALF;
                  endcase
               end
            end
            default: ctrl = '0;
         endcase
      end
   end

   assign ctrl_word = ctrl;

   // A cc-setting instruction in EX forwards its flags to the branch in ID
   always_comb begin
      cc = ex_modify_cc ? alu_flags : psr_cc_q;
      case (id_instr[27:25])
         COND_N:   cond_base = 1'b0;
         COND_E:   cond_base = cc[ICC_Z];
         COND_LE:  cond_base = cc[ICC_Z] | (cc[ICC_N] ^ cc[ICC_V]);
         COND_L:   cond_base = cc[ICC_N] ^ cc[ICC_V];
         COND_LEU: cond_base = cc[ICC_C] | cc[ICC_Z];
         COND_CS:  cond_base = cc[ICC_C];
         COND_NEG: cond_base = cc[ICC_N];
         COND_VS:  cond_base = cc[ICC_V];
         default:  cond_base = 1'b0;
      endcase
      branch_taken = ctrl[CW_B_INSTR] & (cond_base ^ id_instr[28]);
   end

   always_comb begin
      psr_cc_d = psr_cc_q;
      if (ex_modify_cc) psr_cc_d = alu_flags;
   end

   always_ff @(posedge Clk) begin
      if (R) psr_cc_q <= '0;
      else   psr_cc_q <= psr_cc_d;
   end

   assign psr_cc = psr_cc_q;

endmodule

// File: tb/tb_sparc_decode_execute_core.sv
// Randomised and directed bench for sparc_decode_execute_core against a
// behavioural model of decode, ALU, PSR and Bicc evaluation.
module tb_sparc_decode_execute_core;

   logic        Clk;
   logic        R;
   logic [31:0] id_instr;
   logic [15:0] ctrl_word;
   logic [3:0]  ex_alu_op;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic        ex_modify_cc;
   logic [31:0] alu_out;
   logic [3:0]  alu_flags;
   logic [3:0]  psr_cc;
   logic        branch_taken;

   int n_vec = 0;
   int n_err = 0;

   logic [3:0]  m_psr;
   logic [3:0]  m_flags;
   int          arith_tab [64];
   logic [31:0] corners [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
   logic [3:0]  pat_op  [5] = '{4'hE, 4'hE, 4'hE, 4'h2, 4'h0};
   logic [31:0] pat_a   [5] = '{32'h0, 32'h0, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF};
   logic [31:0] pat_b   [5] = '{32'h1, 32'h0, 32'h8000_0000, 32'h1, 32'h2};
   logic [3:0]  pat_icc [5] = '{4'b0000, 4'b0100, 4'b1000, 4'b0010, 4'b0001};

   sparc_decode_execute_core dut (
      .Clk          (Clk),
      .R            (R),
      .id_instr     (id_instr),
      .ctrl_word    (ctrl_word),
      .ex_alu_op    (ex_alu_op),
      .ex_a         (ex_a),
      .ex_b         (ex_b),
      .ex_modify_cc (ex_modify_cc),
      .alu_out      (alu_out),
      .alu_flags    (alu_flags),
      .psr_cc       (psr_cc),
      .branch_taken (branch_taken)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ALU computed in 64-bit integer arithmetic; V is "result does not fit in 32 signed bits"
   task automatic m_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, output logic [31:0] r, output logic [3:0] f);
      longint ua, ub, sa, sb, res, ci;
      logic c, v;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ci = (op == 4'h1 || op == 4'h3) ? longint'(cin) : 64'sd0;
      c = 1'b0;
      v = 1'b0;
      r = '0;
      case (op)
         4'h0, 4'h1: begin
            res = ua + ub + ci;
            r   = res[31:0];
            c   = (res >= 64'sh1_0000_0000);
            res = sa + sb + ci;
            v   = (res != longint'($signed(r)));
         end
         4'h2, 4'h3: begin
            res = ua - ub - ci;
            r   = res[31:0];
            c   = (ua < ub + ci);
            res = sa - sb - ci;
            v   = (res != longint'($signed(r)));
         end
         4'h4: r = a & b;
         4'h5: r = a | b;
         4'h6: r = a ^ b;
         4'h7: r = ~(a ^ b);
         4'h8: r = a & ~b;
         4'h9: r = a | ~b;
         4'hA: r = a << b[4:0];
         4'hB: r = a >> b[4:0];
         4'hC: begin res = sa >>> b[4:0]; r = res[31:0]; end
         4'hD: r = a;
         4'hE: r = b;
         default: r = ~b;
      endcase
      f = {r[31], (r == 32'd0), v, c};
   endtask

   function automatic logic [15:0] m_ctrl(input logic [31:0] i);
      logic [15:0] w;
      logic [5:0]  o3;
      w  = '0;
      o3 = i[24:19];
      if (i == 32'd0) return w;
      case (i[31:30])
         2'b01: begin w[3] = 1'b1; w[7] = 1'b1; end
         2'b00: begin
            if (i[24:22] == 3'b010) begin w[1] = 1'b1; w[0] = i[29]; end
            else if (i[24:22] == 3'b100) begin w[7] = 1'b1; w[13:10] = 4'hE; end
         end
         2'b10: begin
            if (arith_tab[o3] >= 0) begin
               w[7]     = 1'b1;
               w[4]     = o3[4];
               w[13:10] = 4'(arith_tab[o3]);
               w[15]    = (o3 == 6'h38);
            end
         end
         default: begin
            if (o3[5:4] == 2'b00 && o3[1:0] != 2'b11) begin
               w[2]   = 1'b1;
               w[14]  = o3[2];
               w[8]   = !o3[2];
               w[7]   = !o3[2];
               w[9]   = o3[3];
               w[6:5] = (o3[1:0] == 2'b00) ? 2'b10 : (o3[1:0] == 2'b01) ? 2'b00 : 2'b01;
            end
         end
      endcase
      return w;
   endfunction

   function automatic logic m_cond(input logic [3:0] cond, input logic [3:0] icc);
      logic n, z, v, c;
      {n, z, v, c} = icc;
      case (cond)
         4'd0:  return 1'b0;
         4'd1:  return z;
         4'd2:  return z || (n != v);
         4'd3:  return n != v;
         4'd4:  return c || z;
         4'd5:  return c;
         4'd6:  return n;
         4'd7:  return v;
         4'd8:  return 1'b1;
         4'd9:  return !z;
         4'd10: return !(z || (n != v));
         4'd11: return n == v;
         4'd12: return !(c || z);
         4'd13: return !c;
         4'd14: return !n;
         default: return !v;
      endcase
   endfunction

   task automatic drive(input logic [31:0] instr, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic mcc, input logic r);
      logic [31:0] er;
      logic [3:0]  ef, cc;
      logic        is_bicc;
      id_instr = instr; ex_alu_op = op; ex_a = a; ex_b = b; ex_modify_cc = mcc; R = r;
      @(negedge Clk);
      m_alu(op, a, b, m_psr[0], er, ef);
      m_flags = ef;
      cc      = mcc ? ef : m_psr;
      is_bicc = (instr[31:30] == 2'b00) && (instr[24:22] == 3'b010);
      chk("ctrl_word", 32'(ctrl_word), 32'(m_ctrl(instr)));
      chk("alu_out", alu_out, er);
      chk("alu_flags", 32'(alu_flags), 32'(ef));
      chk("psr_cc", 32'(psr_cc), 32'(m_psr));
      chk("branch_taken", 32'(branch_taken), 32'(is_bicc & m_cond(instr[28:25], cc)));
   endtask

   task automatic tick();
      if (R) m_psr = 4'b0000;
      else if (ex_modify_cc) m_psr = m_flags;
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [31:0] bicc(input logic a, input logic [3:0] cond);
      return {2'b00, a, cond, 3'b010, 22'($urandom)};
   endfunction

   function automatic logic [31:0] rand_opnd();
      if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
      return $urandom;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      w = $urandom;
      case ($urandom_range(0, 6))
         0: ;
         1: begin w[31:30] = 2'b00; w[24:22] = 3'b010; end
         2: begin w[31:30] = 2'b00; w[24:22] = 3'b100; end
         3: begin
            w[31:30] = 2'b10;
            for (int t = 0; t < 64 && arith_tab[w[24:19]] < 0; t++) w[24:19] = 6'($urandom);
         end
         4: w[31:30] = 2'b11;
         5: w[31:30] = 2'b01;
         default: w = 32'd0;
      endcase
      return w;
   endfunction

   initial begin
      foreach (arith_tab[k]) arith_tab[k] = -1;
      for (int k = 0; k < 2; k++) begin
         arith_tab[16*k + 0]  = 0;
         arith_tab[16*k + 1]  = 4;
         arith_tab[16*k + 2]  = 5;
         arith_tab[16*k + 3]  = 6;
         arith_tab[16*k + 4]  = 2;
         arith_tab[16*k + 5]  = 8;
         arith_tab[16*k + 6]  = 9;
         arith_tab[16*k + 7]  = 7;
         arith_tab[16*k + 8]  = 1;
         arith_tab[16*k + 12] = 3;
      end
      arith_tab['h25] = 10;
      arith_tab['h26] = 11;
      arith_tab['h27] = 12;
      arith_tab['h38] = 0;
      arith_tab['h3C] = 0;
      arith_tab['h3D] = 0;

      R = 1'b1; id_instr = '0; ex_alu_op = '0; ex_a = '0; ex_b = '0; ex_modify_cc = 1'b0;
      m_psr = 4'b0000; m_flags = 4'b0000;
      @(posedge Clk);
      #1;

      // reset state and NOP
      drive(32'd0, 4'h0, 32'd3, 32'd4, 1'b1, 1'b1);
      chk("rst_psr", 32'(psr_cc), 32'h0);
      chk("nop_ctrl", 32'(ctrl_word), 32'h0);
      tick();

      // overflowing add sets sticky cc
      drive(32'd0, 4'h0, 32'h7FFF_FFFF, 32'h1, 1'b1, 1'b0);
      chk("ovf_out", alu_out, 32'h8000_0000);
      chk("ovf_flags", 32'(alu_flags), 32'hA);
      tick();
      chk("ovf_psr", 32'(psr_cc), 32'hA);

      // borrow feeds ADDX
      drive(32'd0, 4'h2, 32'h0, 32'h1, 1'b1, 1'b0);
      chk("sub_out", alu_out, 32'hFFFF_FFFF);
      chk("sub_nc", 32'({alu_flags[3], alu_flags[0]}), 32'h3);
      tick();
      drive(32'd0, 4'h1, 32'd5, 32'd0, 1'b0, 1'b0);
      chk("addx_out", alu_out, 32'd6);
      tick();

      // decode spot checks
      drive(32'h4000_0004, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("call_ctrl", 32'(ctrl_word), 32'h0088);
      tick();
      drive({2'b11, 5'd3, 6'b000001, 5'd1, 1'b0, 13'd0}, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("ldub_ctrl", 32'(ctrl_word), 32'h0184);
      tick();

      // branch bypass versus registered cc
      drive(bicc(1'b0, 4'b0001), 4'h2, 32'd5, 32'd5, 1'b1, 1'b0);
      chk("be_bypass", 32'(branch_taken), 32'h1);
      tick();
      drive(32'd0, 4'h0, 32'd1, 32'd1, 1'b1, 1'b0);
      tick();
      drive(bicc(1'b0, 4'b0001), 4'h4, 32'd0, 32'd0, 1'b0, 1'b0);
      chk("be_psr", 32'(branch_taken), 32'h0);
      tick();

      // shifts and logic-op flags
      drive(32'd0, 4'hC, 32'h8000_0000, 32'd4, 1'b0, 1'b0);
      chk("sra", alu_out, 32'hF800_0000);
      tick();
      drive(32'd0, 4'hA, 32'h1, 32'd31, 1'b0, 1'b0);
      chk("sll", alu_out, 32'h8000_0000);
      tick();
      drive(32'd0, 4'h6, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      chk("logic_cv", 32'(alu_flags[1:0]), 32'h0);
      tick();

      // reset mid-run clears a set carry so ADDX adds nothing extra
      drive(32'd0, 4'h2, 32'h0, 32'h1, 1'b1, 1'b0);
      tick();
      drive(32'd0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b1);
      tick();
      drive(32'd0, 4'h1, 32'd5, 32'd0, 1'b0, 1'b0);
      chk("addx_after_rst", alu_out, 32'd5);
      tick();

      // all conditions against each icc pattern, via the EX bypass
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 16; c++) begin
            drive(bicc(c[0], 4'(c)), pat_op[p], pat_a[p], pat_b[p], 1'b1, 1'b0);
            if (c == 0) chk("sweep_icc", 32'(alu_flags), 32'(pat_icc[p]));
            if (c == 8) chk("ba", 32'(branch_taken), 32'h1);
            if (c == 0) chk("bn", 32'(branch_taken), 32'h0);
            tick();
         end
      end

      for (int k = 0; k < 400; k++) begin
         drive(rand_instr(), 4'($urandom_range(0, 15)), rand_opnd(), rand_opnd(),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 29) == 0));
         tick();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/sparc_decode_execute_core.md
Name: sparc_decode_execute_core

Overview:
Combined decode/execute slice of the 5-stage SPARC-subset pipeline. It holds three parts:
- the ID-stage control decoder, which turns a 32-bit instruction into a 16-bit control word;
- the EX-stage 32-bit ALU with N/Z/V/C flags;
- the branch-condition evaluator (Bicc conditions), plus the registered condition-code register (PSR icc) that feeds ALU carry-in and branch evaluation.

Parameters:
- none; widths are fixed by the architecture (32-bit datapath, 4-bit ALU opcode, 4-bit icc).

Ports:
- Clk            in   1   system clock, rising-edge
- R              in   1   reset; synchronous, active-high
- id_instr       in   32  instruction currently in ID
- ctrl_word      out  16  {jmpl,rw,alu_op[3:0],se_dm,load,rf_en,size[1:0],modify_cc,call,dm_en,b_instr,a}, bit15..bit0
- ex_alu_op      in   4   ALU opcode of EX instruction
- ex_a           in   32  operand A
- ex_b           in   32  operand B (already source-operand-2 handled)
- ex_modify_cc   in   1   EX instruction writes icc
- alu_out        out  32  ALU result
- alu_flags      out  4   {N,Z,V,C} of current ALU op
- psr_cc         out  4   registered icc {N,Z,V,C}
- branch_taken   out  1   evaluated Bicc outcome for id_instr

Behaviour:
Control decode (combinational; op = id_instr[31:30])
- id_instr == 0 (NOP) produces ctrl_word = 0.
- Any unlisted encoding produces ctrl_word = 0.
- op=01, CALL: call=1, rf_en=1; all other bits 0.
- op=00, op2=id_instr[24:22]:
  - 010 Bicc: b_instr=1, a=id_instr[29].
  - 100 SETHI (nonzero word): rf_en=1, alu_op=1110.
- op=10, op3=id_instr[24:19]: rf_en=1, modify_cc=op3[4].
  - ADD 0000, ADDX 0001, SUB 0010, SUBX 0011.
  - AND 0100, OR 0101, XOR 0110, XNOR 0111, ANDN 1000, ORN 1001 (cc variants share the same alu_op).
  - SLL 1010, SRL 1011, SRA 1100.
  - JMPL (111000): jmpl=1, alu_op=0000.
  - SAVE/RESTORE: alu_op=0000.
- op=11, load/store: dm_en=1, alu_op=0000.
  - rw=op3[2] (1 = store); load=~op3[2]; rf_en=load; se_dm=op3[3].
  - size from op3[1:0]: 00→10 (word), 01→00 (byte), 10→01 (half).

ALU (combinational)
- 0000 A+B
- 0001 A+B+Cin
- 0010 A−B
- 0011 A−B−Cin
- 0100 A&B
- 0101 A|B
- 0110 A^B
- 0111 ~(A^B)
- 1000 A&~B
- 1001 A|~B
- 1010 A<<B[4:0]
- 1011 A>>B[4:0] (logical)
- 1100 A>>>B[4:0] (arithmetic)
- 1101 A
- 1110 B
- 1111 ~B

Carry-in and flags
- Cin = psr_cc[0] (registered C).
- N = out[31] and Z = (out==0) for all ops.
- C and V are valid for ops 0000–0011 only, 0 otherwise.
  - Add: C = carry-out of bit 31.
  - Subtract: C = borrow.
  - V = two's-complement overflow.

PSR
- On a rising Clk edge: if R, psr_cc←0000; else if ex_modify_cc, psr_cc←alu_flags; otherwise it holds.

Branch evaluation (combinational)
- cc = ex_modify_cc ? alu_flags : psr_cc. This bypass means a cc-setting instruction in EX is visible in the same cycle.
- cond = id_instr[28:25]:
  - 0000 never
  - 0001 Z
  - 0010 Z|(N^V)
  - 0011 N^V
  - 0100 C|Z
  - 0101 C
  - 0110 N
  - 0111 V
  - 1000 always
  - 1001 ~Z
  - 1010 ~(Z|(N^V))
  - 1011 ~(N^V)
  - 1100 ~(C|Z)
  - 1101 ~C
  - 1110 ~N
  - 1111 ~V
- branch_taken = b_instr & cond_result; it is 0 whenever id_instr is not Bicc.

Reset
- R asserted during operation clears psr_cc on the next edge; combinational outputs are unaffected.
- ADDX immediately after reset uses Cin = 0.

Decomposition:
- Shared package: ALU opcode constants, SPARC op/op2/op3 constants, Bicc condition codes, ctrl_word bit-index constants.
- One sub-module is natural: sparc_alu32 (pure combinational ALU with flags).
- Decoder and branch logic stay in the top module.

Test Plan:
1. Reset and sticky CC:
   - R=1 for one edge → psr_cc=0000.
   - ex_alu_op=0000, A=0x7FFFFFFF, B=1, modify_cc=1 → alu_out=0x80000000, flags=1010; psr_cc=1010 after the edge.
2. Carry chain:
   - SUB 0x0−0x1 with modify_cc → out=0xFFFFFFFF, flags N=1, C=1.
   - Next cycle ADDX 5+0 → out=6.
3. Decode coverage:
   - id_instr=0 → ctrl_word=0.
   - CALL 0x40000004 → ctrl_word=0x0088.
   - LDUB (op=11, op3=000001) → dm_en=1, load=1, rw=0, size=00, se_dm=0, rf_en=1.
4. Branch bypass:
   - EX SUBcc 5−5 (Z=1) with id_instr BE (cond 0001) → branch_taken=1 in the same cycle.
   - With modify_cc=0 and psr_cc Z=0 → 0.
5. Shifts:
   - SRA A=0x80000000, B=4 → 0xF8000000.
   - SLL A=1, B=31 → 0x80000000.
   - Logical ops give C=V=0.
6. All 16 Bicc conditions:
   - Swept against the icc patterns 0000, 0100, 1000, 0010, 0001.
   - BA gives 1 and BN gives 0 regardless of icc.
